// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline stall/flush/halt sequencer.
//   - ST_* : 2-bit state encodings (also exported on the debug state output)
//   - ctrl_state_e : FSM state type built on the ST_* encodings
//   - ctrl_out_t   : bundle of per-cycle pipeline register controls
//   - NOP_INSTR    : instruction loaded by a flushing pipeline register (addi x0,x0,0)
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_DMEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN     = 2'd2;
  localparam logic [1:0] ST_HALTED    = 2'd3;

  typedef enum logic [1:0] {
    S_RUN       = ST_RUN,
    S_DMEM_WAIT = ST_DMEM_WAIT,
    S_DRAIN     = ST_DRAIN,
    S_HALTED    = ST_HALTED
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
    logic halted;
  } ctrl_out_t;

  // Everything advances, nothing is squashed.
  localparam ctrl_out_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                         id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
                                         mem_wb_flush: 1'b0, halted: 1'b0};
  // Front of the pipe holds while MEM waits; WB receives a bubble.
  localparam ctrl_out_t CTRL_FREEZE  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0,
                                         mem_wb_flush: 1'b1, halted: 1'b0};
  // Value held while reset is asserted: nothing loads, every flush is raised.
  localparam ctrl_out_t CTRL_RESET   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                         id_ex_write: 1'b0, id_ex_flush: 1'b1, ex_mem_write: 1'b0,
                                         mem_wb_flush: 1'b1, halted: 1'b0};
  localparam ctrl_out_t CTRL_HALTED  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0,
                                         mem_wb_flush: 1'b0, halted: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard information from the datapath and the
// resulting pipeline register controls.
//   master : datapath / debug side (drives hazard info and debug requests)
//   slave  : the hazard controller (drives register controls, status, counters)
// Memory handshake: dmem_req_mem is the request, dmem_ready is the completion.
// The access completes on a cycle where both are high; on any cycle with
// dmem_req_mem=1 and dmem_ready=0 the controller freezes the pipeline, and the
// datapath must keep dmem_req_mem high until dmem_ready is seen.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             uses_rs1_id;
  logic             uses_rs2_id;
  logic             mem_read_ex;
  logic [4:0]       rd_ex;
  logic             branch_taken_ex;
  logic             dmem_req_mem;
  logic             dmem_ready;
  logic             halt_req;
  logic             resume_req;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_flush;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [1:0]       state_dbg;

  modport master (
    output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, mem_read_ex, rd_ex,
           branch_taken_ex, dmem_req_mem, dmem_ready, halt_req, resume_req,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, halted, mem_timeout, stall_cycles,
           flush_events, state_dbg
  );

  modport slave (
    input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, mem_read_ex, rd_ex,
           branch_taken_ex, dmem_req_mem, dmem_ready, halt_req, resume_req,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, halted, mem_timeout, stall_cycles,
           flush_events, state_dbg
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use detection.
//   i_rs1_id/i_rs2_id        : source registers of the ID instruction
//   i_uses_rs1_id/i_uses_rs2_id : the ID instruction actually reads that source
//   i_mem_read_ex, i_rd_ex   : EX instruction is a load, and its destination
//   o_load_use               : ID must wait one cycle for the load result
module hazard_detect (
  input  logic [4:0] i_rs1_id,
  input  logic [4:0] i_rs2_id,
  input  logic       i_uses_rs1_id,
  input  logic       i_uses_rs2_id,
  input  logic       i_mem_read_ex,
  input  logic [4:0] i_rd_ex,
  output logic       o_load_use
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_uses_rs1_id && (i_rs1_id == i_rd_ex);
  assign w_rs2_hit  = i_uses_rs2_id && (i_rs2_id == i_rd_ex);
  // x0 is hard-wired zero, so a load to x0 never creates a dependency.
  assign o_load_use = i_mem_read_ex && (i_rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/halt sequencer for the 5-stage pipeline.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : hazard inputs, debug halt/resume requests, per-register
//                  write/flush controls, halted, sticky mem_timeout,
//                  stall/flush counters and the FSM state (state_dbg).
// Controls are combinational from the registered state plus current inputs.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input logic                  clock,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(WAIT_TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_PRE   = WC_W'(WAIT_TIMEOUT - 1);

  ctrl_state_e      r_state;
  ctrl_state_e      r_ret_state;
  logic [DC_W-1:0]  r_drain_cnt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic             w_lu;
  logic             w_mw;
  ctrl_out_t        w_ctl;
  ctrl_state_e      w_next_state;
  ctrl_state_e      w_ret_next;
  logic [DC_W-1:0]  w_drain_next;
  logic [WC_W-1:0]  w_wait_next;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_timeout_set;
  logic             w_freeze;

  hazard_detect u_hazard_detect (
    .i_rs1_id      (bus.rs1_id),
    .i_rs2_id      (bus.rs2_id),
    .i_uses_rs1_id (bus.uses_rs1_id),
    .i_uses_rs2_id (bus.uses_rs2_id),
    .i_mem_read_ex (bus.mem_read_ex),
    .i_rd_ex       (bus.rd_ex),
    .o_load_use    (w_lu)
  );

  assign w_mw = bus.dmem_req_mem && !bus.dmem_ready;

  always_comb begin
    w_ctl         = CTRL_DEFAULT;
    w_next_state  = r_state;
    w_ret_next    = r_ret_state;
    w_drain_next  = r_drain_cnt;
    w_wait_next   = r_wait_cnt;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_timeout_set = 1'b0;
    w_freeze      = 1'b0;

    case (r_state)
      S_RUN, S_DRAIN: begin
        if (r_state == S_DRAIN) begin
          // Fetch is stopped; IF/ID fills with NOPs while the rest drains.
          w_ctl.pc_write    = 1'b0;
          w_ctl.if_id_flush = 1'b1;
        end
        if (w_mw) begin
          w_freeze     = 1'b1;
          w_next_state = S_DMEM_WAIT;
          w_ret_next   = r_state;
        end else if (bus.branch_taken_ex) begin
          // In DRAIN the PC still takes the target so resume restarts there.
          w_ctl.pc_write    = 1'b1;
          w_ctl.if_id_flush = 1'b1;
          w_ctl.id_ex_flush = 1'b1;
          w_flush_inc       = 1'b1;
        end else if (w_lu) begin
          // IF/ID holds the dependent instruction, so it must not be flushed.
          w_ctl.pc_write    = 1'b0;
          w_ctl.if_id_write = 1'b0;
          w_ctl.if_id_flush = 1'b0;
          w_ctl.id_ex_flush = 1'b1;
          w_stall_inc       = 1'b1;
        end

        if (!w_mw) begin
          if (r_state == S_RUN) begin
            if (bus.halt_req) begin
              w_next_state = S_DRAIN;
              w_drain_next = '0;
            end
          end else if (bus.branch_taken_ex || !w_lu) begin
            // Only cycles where everything moves forward count toward draining.
            if (r_drain_cnt == DRAIN_LAST) begin
              w_next_state = S_HALTED;
            end else begin
              w_drain_next = r_drain_cnt + DC_W'(1);
            end
          end
        end
      end

      S_DMEM_WAIT: begin
        if (bus.dmem_ready) begin
          w_next_state = r_ret_state;
          w_wait_next  = '0;
        end else begin
          w_freeze = 1'b1;
        end
      end

      S_HALTED: begin
        w_ctl = CTRL_HALTED;
        if (bus.resume_req) begin
          w_next_state = S_RUN;
        end
      end

      default: begin
        w_next_state = S_RUN;
      end
    endcase

    // Every frozen cycle is one wait cycle; the wait counter saturates at the limit.
    if (w_freeze) begin
      w_ctl       = CTRL_FREEZE;
      w_stall_inc = 1'b1;
      if (r_wait_cnt == WAIT_PRE) begin
        w_timeout_set = 1'b1;
      end
      if (r_wait_cnt != WAIT_LIMIT) begin
        w_wait_next = r_wait_cnt + WC_W'(1);
      end
    end

    if (reset) begin
      w_ctl = CTRL_RESET;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_RUN;
      r_ret_state    <= S_RUN;
      r_drain_cnt    <= '0;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state     <= w_next_state;
      r_ret_state <= w_ret_next;
      r_drain_cnt <= w_drain_next;
      r_wait_cnt  <= w_wait_next;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
      if (w_stall_inc) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_inc) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write     = w_ctl.pc_write;
  assign bus.if_id_write  = w_ctl.if_id_write;
  assign bus.if_id_flush  = w_ctl.if_id_flush;
  assign bus.id_ex_write  = w_ctl.id_ex_write;
  assign bus.id_ex_flush  = w_ctl.id_ex_flush;
  assign bus.ex_mem_write = w_ctl.ex_mem_write;
  assign bus.mem_wb_flush = w_ctl.mem_wb_flush;
  assign bus.halted       = w_ctl.halted;
  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;
  assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus for pipeline_hazard_ctrl.
// Expected control vectors are queued as each cycle is driven and compared
// when the outputs are sampled mid-cycle; counters are checked against the
// bench's own running totals.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 32;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush, halted}
  localparam logic [7:0] C_DEF = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] C_LU  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] C_BR  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] C_FRZ = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [7:0] C_DRN = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] C_HLT = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [7:0] C_RST = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES (4),
    .WAIT_TIMEOUT (8),
    .CNT_W        (CNT_W)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [7:0] w_obs;
  assign w_obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                  bus.id_ex_flush, bus.ex_mem_write, bus.mem_wb_flush, bus.halted};

  // ---------------- scoreboard ----------------
  logic [7:0]       exp_q[$];
  int               n_total;
  int               n_bad;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;

  task automatic check(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.rs1_id          = 5'd0;
    bus.rs2_id          = 5'd0;
    bus.uses_rs1_id     = 1'b0;
    bus.uses_rs2_id     = 1'b0;
    bus.mem_read_ex     = 1'b0;
    bus.rd_ex           = 5'd0;
    bus.branch_taken_ex = 1'b0;
    bus.dmem_req_mem    = 1'b0;
    bus.dmem_ready      = 1'b1;
    bus.halt_req        = 1'b0;
    bus.resume_req      = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    bus.mem_read_ex = 1'b1;
    bus.rd_ex       = rd;
    bus.rs1_id      = rs1;
    bus.uses_rs1_id = u1;
    bus.rs2_id      = rs2;
    bus.uses_rs2_id = u2;
  endtask

  // Called at a falling edge with inputs already set; samples mid-low phase,
  // then returns at the next falling edge (one rising edge later).
  task automatic cycle(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    #2;
    e = exp_q.pop_front();
    check(tag, {24'd0, w_obs}, {24'd0, e});
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_stall"}, bus.stall_cycles, m_stall);
    check({tag, "_flush"}, bus.flush_events, m_flush);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       mr, u1, u2, br, lu;
    logic [4:0] rd, r1, r2;
    logic [7:0] e;
    n_total = 0;
    n_bad   = 0;
    m_stall = '0;
    m_flush = '0;
    rst     = 1'b1;
    idle();
    #1;
    check("rst_ctl", {24'd0, w_obs}, {24'd0, C_RST});
    check("rst_state", {30'd0, bus.state_dbg}, {30'd0, ST_RUN});
    check("rst_timeout", {31'd0, bus.mem_timeout}, 32'd0);
    check_counters("rst");
    @(negedge clk);
    rst = 1'b0;

    // Load-use on rs1: exactly one bubble.
    set_lu(5'd5, 5'd5, 1'b1, 5'd9, 1'b0);
    cycle("lu_rs1", C_LU);
    m_stall++;
    idle();
    cycle("lu_after", C_DEF);
    check_counters("lu_rs1");
    // Load to x0 never stalls.
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    cycle("lu_x0", C_DEF);
    // Matching rs1 but not read: no stall.
    set_lu(5'd6, 5'd6, 1'b0, 5'd2, 1'b1);
    cycle("lu_unused", C_DEF);
    // Load-use on rs2.
    set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    cycle("lu_rs2", C_LU);
    m_stall++;
    idle();
    check_counters("lu_rs2");

    // Branch wins over load-use.
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    bus.branch_taken_ex = 1'b1;
    cycle("br_lu", C_BR);
    m_flush++;
    idle();
    check_counters("br_lu");

    // Three memory wait cycles with a branch held in EX.
    bus.dmem_req_mem    = 1'b1;
    bus.dmem_ready      = 1'b0;
    bus.branch_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("mw_freeze", C_FRZ);
      m_stall++;
    end
    check("mw_state", {30'd0, bus.state_dbg}, {30'd0, ST_DMEM_WAIT});
    bus.dmem_ready = 1'b1;
    cycle("mw_release", C_DEF);
    check_counters("mw_release");
    cycle("mw_branch", C_BR);
    m_flush++;
    idle();
    check_counters("mw_branch");

    // Timeout: ten wait cycles, flag rises after the eighth.
    bus.dmem_req_mem = 1'b1;
    bus.dmem_ready   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("to_flag", {31'd0, bus.mem_timeout}, {31'd0, (i >= 8)});
      cycle("to_freeze", C_FRZ);
      m_stall++;
    end
    check("to_set", {31'd0, bus.mem_timeout}, 32'd1);
    bus.dmem_ready = 1'b1;
    cycle("to_release", C_DEF);
    idle();
    cycle("to_idle", C_DEF);
    check("to_sticky", {31'd0, bus.mem_timeout}, 32'd1);
    check_counters("to");

    // resume_req outside HALTED does nothing.
    bus.resume_req = 1'b1;
    cycle("resume_run", C_DEF);
    idle();
    cycle("resume_run2", C_DEF);

    // Halt with no hazards: four drain cycles then halted.
    bus.halt_req = 1'b1;
    cycle("halt_req", C_DEF);
    bus.halt_req = 1'b0;
    check("drain_state", {30'd0, bus.state_dbg}, {30'd0, ST_DRAIN});
    for (int i = 0; i < 4; i++) cycle("drain", C_DRN);
    cycle("halted", C_HLT);
    bus.halt_req = 1'b1;
    cycle("halt_in_halted", C_HLT);
    bus.halt_req   = 1'b0;
    bus.resume_req = 1'b1;
    cycle("resume_edge", C_HLT);
    idle();
    cycle("resumed", C_DEF);

    // Halt again with one load-use in DRAIN: five drain cycles.
    bus.halt_req = 1'b1;
    cycle("halt2_req", C_DEF);
    bus.halt_req = 1'b0;
    cycle("drain2", C_DRN);
    set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    cycle("drain2_lu", C_LU);
    m_stall++;
    idle();
    for (int i = 0; i < 3; i++) cycle("drain2", C_DRN);
    cycle("halted2", C_HLT);
    bus.halt_req   = 1'b1;
    bus.resume_req = 1'b1;
    cycle("resume_wins", C_HLT);
    idle();
    cycle("resumed2", C_DEF);
    check_counters("halt2");

    // Random hazard mix, no memory waits or debug requests.
    for (int i = 0; i < 24; i++) begin
      mr = 1'($urandom_range(0, 1));
      u1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 3) == 0);
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      set_lu(rd, r1, u1, r2, u2);
      bus.mem_read_ex     = mr;
      bus.branch_taken_ex = br;
      lu = mr && (rd != 5'd0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
      if (br) begin
        e = C_BR;
        m_flush++;
      end else if (lu) begin
        e = C_LU;
        m_stall++;
      end else begin
        e = C_DEF;
      end
      cycle("rand", e);
    end
    idle();
    check_counters("rand");

    // Reset pulse clears the sticky timeout and counters.
    rst = 1'b1;
    #1;
    check("rst2_timeout", {31'd0, bus.mem_timeout}, 32'd0);
    m_stall = '0;
    m_flush = '0;
    check_counters("rst2");
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a memory wait.
    bus.dmem_req_mem = 1'b1;
    bus.dmem_ready   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle("pre_rst_freeze", C_FRZ);
      m_stall++;
    end
    #2;
    check("pre_rst_stall", bus.stall_cycles, m_stall);
    check("pre_rst_state", {30'd0, bus.state_dbg}, {30'd0, ST_DMEM_WAIT});
    #1;
    rst = 1'b1;
    #1;
    m_stall = '0;
    check("async_rst_ctl", {24'd0, w_obs}, {24'd0, C_RST});
    check("async_rst_state", {30'd0, bus.state_dbg}, {30'd0, ST_RUN});
    check_counters("async_rst");
    @(negedge clk);
    rst = 1'b0;
    idle();
    cycle("post_rst", C_DEF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/halt sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB) in datapath.
- Decides every cycle which pipeline registers advance, hold or take a bubble:
  - load-use hazards,
  - EX-stage taken branches,
  - multi-cycle data-memory waits,
  - debug halt/drain/resume requests.
- Keeps stall and flush counters for the debug testbenches.
- Control outputs are combinational from state plus inputs; state and counters are registered.

Parameters:
- DRAIN_CYCLES, 4, advancing cycles needed to empty ID..WB after fetch stops.
- WAIT_TIMEOUT, 64, consecutive DMEM_WAIT cycles before mem_timeout is set.
- CNT_W, 32, width of the performance counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1_id  in  5  rs1 of the instruction in ID.
- rs2_id  in  5  rs2 of the instruction in ID.
- uses_rs1_id  in  1  ID instruction reads rs1.
- uses_rs2_id  in  1  ID instruction reads rs2.
- mem_read_ex  in  1  EX instruction is a load.
- rd_ex  in  5  destination register of the EX instruction.
- branch_taken_ex  in  1  EX resolved a taken branch or jump.
- dmem_req_mem  in  1  MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  debug halt request, level.
- resume_req  in  1  debug resume request, level.
- pc_write  out  1  PC register loads its next value.
- if_id_write  out  1  IF/ID register loads.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_write  out  1  ID/EX register loads.
- id_ex_flush  out  1  ID/EX register loads a NOP.
- ex_mem_write  out  1  EX/MEM register loads.
- mem_wb_flush  out  1  MEM/WB register loads a NOP.
- halted  out  1  pipeline is empty and frozen.
- mem_timeout  out  1  sticky data-memory wait timeout.
- stall_cycles  out  CNT_W  count of load-use and DMEM_WAIT cycles.
- flush_events  out  CNT_W  count of taken-branch flushes.

Behaviour:
Reset (asynchronous, active-high):
- state=RUN; all counters 0; mem_timeout=0.
- While reset is high: all *_write=0, all *_flush=1, halted=0.

States: RUN, DMEM_WAIT, DRAIN, HALTED. Default outputs: all writes=1, all flushes=0, halted=0.

Condition terms:
- lu = mem_read_ex & (rd_ex!=0) & ((uses_rs1_id & rs1_id==rd_ex) | (uses_rs2_id & rs2_id==rd_ex)).
- mw = dmem_req_mem & ~dmem_ready.

Priority in RUN/DRAIN, highest first:
1. mw: freeze (pc/if_id/id_ex/ex_mem write=0), mem_wb_flush=1.
   - Go to DMEM_WAIT; the return target is the current state (RUN or DRAIN).
   - branch_taken_ex and lu are ignored.
2. branch_taken_ex: pc_write=1, if_id_flush=1, id_ex_flush=1; flush_events+1. lu is ignored.
3. lu: pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles+1. Exactly one bubble per hazard.

DMEM_WAIT:
- Freeze as in priority 1 every cycle; stall_cycles+1 per cycle; wait_cnt+1 per cycle.
- When wait_cnt reaches WAIT_TIMEOUT, set mem_timeout; it stays set until reset. The controller keeps waiting.
- When dmem_ready=1: outputs are the default for that cycle, wait_cnt clears, and the state returns to the return target.

RUN + halt_req:
- Enter DRAIN on the next edge; drain_cnt=0.
- If halt_req coincides with a branch, the branch is handled in the same cycle.

DRAIN:
- pc_write=0 and if_id_flush=1, except on a taken branch, where pc_write=1 so the target is captured for resume.
- drain_cnt increments only on cycles with no mw and no lu.
- When drain_cnt reaches DRAIN_CYCLES-1 on an advancing cycle, go to HALTED.

HALTED:
- All writes=0, flushes=0, halted=1.
- resume_req: go to RUN on the next edge; halted drops in that same edge.
- halt_req has no effect while HALTED; resume_req has no effect outside HALTED.
- halt_req and resume_req high together in HALTED: resume wins.

Counters:
- Wrap modulo 2^CNT_W.
- Reset mid-operation in any state returns to RUN with all counters and flags cleared immediately.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding localparams ST_RUN, ST_DMEM_WAIT, ST_DRAIN, ST_HALTED (2 bits);
  - NOP instruction constant 32'h00000013 for the flushing registers.
- Sub-module hazard_detect: purely combinational lu computation, reused by the forwarding unit tests.
- Everything else stays in this module.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, uses_rs1_id=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle; stall_cycles=1. Same stimulus with rd_ex=0 -> no stall.
- Branch and load-use together: branch_taken_ex=1 with the lu condition -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_events=1; stall_cycles unchanged.
- dmem_ready low 3 cycles with dmem_req_mem=1 and branch_taken_ex held high -> 3 freeze cycles with mem_wb_flush=1; stall_cycles=3; flush_events=1 only after release.
- Timeout: WAIT_TIMEOUT=8, dmem_ready low 10 cycles -> mem_timeout rises after the 8th wait cycle; still 1 after ready; cleared only by reset.
- Halt: halt_req in RUN with no hazards -> DRAIN for 4 cycles with pc_write=0, then halted=1. resume_req -> halted=0 and pc_write=1 the next cycle. Repeat with one lu during DRAIN -> halted after 5 cycles.
- Reset asserted asynchronously mid-DMEM_WAIT with stall_cycles=7 -> outputs go to reset values immediately; stall_cycles=0; state=RUN.
